// File: rtl/serial_vector_deserializer_pkg.sv
// Shared types and helpers for the vector-reverse / serial deserializer family.
// Holds the output-register state encoding and the bit-counter width helper.
package serial_vector_deserializer_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // Counter width able to hold 0..width-1; never narrower than one bit.
    function automatic int cnt_w(input int width);
        if (width < 2) begin
            return 1;
        end else begin
            return $clog2(width);
        end
    endfunction

endpackage

// File: rtl/serial_shift_collector.sv
// Shift register and bit counter that assemble serial bits into WIDTH-bit words.
// Reports completion combinationally so the parent can capture the word on the same edge.
module serial_shift_collector
    import serial_vector_deserializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_bit,
    input  logic                    i_valid,
    input  logic                    i_frame_start,
    output logic [WIDTH-1:0]        o_word,
    output logic                    o_done,
    output logic [cnt_w(WIDTH)-1:0] o_bit_count,
    output logic                    o_busy
);

    localparam int             CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_sr_next;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_next;
    logic             r_busy;
    logic             w_done;

    // Next shift value and count; frame_start restarts from an empty word and wins over completion.
    always_comb begin
        w_base     = r_sr;
        w_sr_next  = r_sr;
        w_cnt_next = r_cnt;
        w_done     = 1'b0;
        if (i_valid) begin
            if (i_frame_start) begin
                w_base = {WIDTH{1'b0}};
            end else begin
                w_base = r_sr;
            end
            if (MSB_FIRST) begin
                w_sr_next = {w_base[WIDTH-2:0], i_bit};
            end else begin
                w_sr_next = {i_bit, w_base[WIDTH-1:1]};
            end
            if (i_frame_start) begin
                w_cnt_next = CW'(1);
            end else if (r_cnt == LAST_IDX) begin
                w_cnt_next = {CW{1'b0}};
                w_done     = 1'b1;
            end else begin
                w_cnt_next = r_cnt + CW'(1);
            end
        end else begin
            w_sr_next  = r_sr;
            w_cnt_next = r_cnt;
        end
    end

    // Shift register, counter and registered busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr   <= {WIDTH{1'b0}};
            r_cnt  <= {CW{1'b0}};
            r_busy <= 1'b0;
        end else begin
            r_sr   <= w_sr_next;
            r_cnt  <= w_cnt_next;
            r_busy <= (w_cnt_next != {CW{1'b0}});
        end
    end

    assign o_word      = w_sr_next;
    assign o_done      = w_done;
    assign o_bit_count = r_cnt;
    assign o_busy      = r_busy;

endmodule

// File: rtl/serial_vector_deserializer.sv
// Serial-to-parallel deserializer: assembles WIDTH-bit words and presents them through
// a one-word holding register with valid/ready handshake and a drop (overflow) pulse.
module serial_vector_deserializer
    import serial_vector_deserializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    input  logic                    frame_start,
    output logic [WIDTH-1:0]        out_vector,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [cnt_w(WIDTH)-1:0] bit_count,
    output logic                    overflow,
    output logic                    busy
);

    out_state_e       r_state;
    out_state_e       w_state_next;
    logic [WIDTH-1:0] r_out_vector;
    logic             r_overflow;
    logic [WIDTH-1:0] w_word;
    logic             w_done;
    logic             w_load;
    logic             w_drop;

    serial_shift_collector #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_collector (
        .clk           (clk),
        .rst           (rst),
        .i_bit         (bit_in),
        .i_valid       (bit_valid),
        .i_frame_start (frame_start),
        .o_word        (w_word),
        .o_done        (w_done),
        .o_bit_count   (bit_count),
        .o_busy        (busy)
    );

    // Holding-register FSM: a consumed slot can be refilled on the same edge, an unconsumed one drops.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_done) begin
                    w_state_next = ST_FULL;
                    w_load       = 1'b1;
                end else begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_done) begin
                    w_state_next = ST_FULL;
                    if (out_ready) begin
                        w_load = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                    end
                end else if (out_ready) begin
                    w_state_next = ST_EMPTY;
                end else begin
                    w_state_next = ST_FULL;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
    end

    // State, held word and overflow pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_EMPTY;
            r_out_vector <= {WIDTH{1'b0}};
            r_overflow   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_overflow <= w_drop;
            if (w_load) begin
                r_out_vector <= w_word;
            end else begin
                r_out_vector <= r_out_vector;
            end
        end
    end

    assign out_vector = r_out_vector;
    assign out_valid  = (r_state == ST_FULL);
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_serial_vector_deserializer.sv
// Drives one serial stream into an MSB-first and an LSB-first deserializer and checks
// both against a word scoreboard plus a bit-counter / holding-register reference model.
module tb_serial_vector_deserializer;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       frame_start;
    logic       out_ready;
    logic [7:0] vec_m, vec_l;
    logic       val_m, val_l, ovf_m, ovf_l, busy_m, busy_l;
    logic [2:0] cnt_m, cnt_l;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] q_m[$];
    logic [7:0] q_l[$];
    int         m_cnt    = 0;
    logic       exp_ovf  = 1'b0;
    logic [7:0] cur_word = 8'h00;

    always #5 clk = ~clk;

    serial_vector_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .out_vector(vec_m), .out_valid(val_m),
        .out_ready(out_ready), .bit_count(cnt_m), .overflow(ovf_m), .busy(busy_m)
    );

    serial_vector_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .out_vector(vec_l), .out_valid(val_l),
        .out_ready(out_ready), .bit_count(cnt_l), .overflow(ovf_l), .busy(busy_l)
    );

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check handshake before the edge, update the model, check registered outputs after it.
    task automatic step(input logic bv, input logic bi, input logic fs);
        logic comp;
        bit_valid   = bv;
        bit_in      = bi;
        frame_start = fs;
        check("out_valid_msb", 32'(val_m), 32'(q_m.size() != 0));
        check("out_valid_lsb", 32'(val_l), 32'(q_l.size() != 0));
        if (q_m.size() != 0 && out_ready) begin
            check("word_msb", 32'(vec_m), 32'(q_m.pop_front()));
            check("word_lsb", 32'(vec_l), 32'(q_l.pop_front()));
        end
        comp = bv && !fs && (m_cnt == W - 1);
        if (bv) begin
            if (fs)        m_cnt = 1;
            else if (comp) m_cnt = 0;
            else           m_cnt = m_cnt + 1;
        end
        exp_ovf = 1'b0;
        if (comp) begin
            if (q_m.size() == 0) begin
                q_m.push_back(cur_word);
                q_l.push_back(rev8(cur_word));
            end else begin
                exp_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("overflow_msb", 32'(ovf_m), 32'(exp_ovf));
        check("overflow_lsb", 32'(ovf_l), 32'(exp_ovf));
        check("bit_count_msb", 32'(cnt_m), 32'(m_cnt));
        check("bit_count_lsb", 32'(cnt_l), 32'(m_cnt));
        check("busy_msb", 32'(busy_m), 32'(m_cnt != 0));
        check("busy_lsb", 32'(busy_l), 32'(m_cnt != 0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 1'($urandom));
    endtask

    task automatic send_word(input logic [7:0] w, input logic fs_first);
        cur_word = w;
        for (int i = 7; i >= 0; i--) step(1'b1, w[i], fs_first && (i == 7));
    endtask

    task automatic send_word_gaps(input logic [7:0] w);
        cur_word = w;
        for (int i = 7; i >= 0; i--) begin
            idle(int'($urandom_range(0, 4)));
            step(1'b1, w[i], 1'b0);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bit_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q_m.delete();
        q_l.delete();
        m_cnt   = 0;
        exp_ovf = 1'b0;
        check("rst_vec_msb", 32'(vec_m), 32'h0);
        check("rst_vec_lsb", 32'(vec_l), 32'h0);
        check("rst_valid", 32'({val_m, val_l}), 32'h0);
        check("rst_ovf", 32'({ovf_m, ovf_l}), 32'h0);
        check("rst_cnt", 32'({cnt_m, cnt_l}), 32'h0);
        check("rst_busy", 32'({busy_m, busy_l}), 32'h0);
    endtask

    initial begin
        bit_in      = 1'b0;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        out_ready   = 1'b1;
        rst         = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // 1/2: ready consumer, both bit orders
        send_word(8'h55, 1'b0);
        idle(2);
        send_word(8'hF0, 1'b0);
        send_word(8'h33, 1'b0);
        idle(2);

        // 3: stalled consumer drops the second word
        out_ready = 1'b0;
        send_word(8'hF0, 1'b0);
        send_word(8'h0F, 1'b0);
        idle(3);
        out_ready = 1'b1;
        idle(2);

        // 4: frame_start resync after 3 bits, and at the completion position
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        send_word(8'hA5, 1'b1);
        idle(2);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0);
        send_word(8'h5A, 1'b1);
        idle(2);

        // back-to-back with a stall on the first word, ready during the second completion
        out_ready = 1'b0;
        send_word(8'h12, 1'b0);
        out_ready = 1'b1;
        send_word(8'h34, 1'b0);
        idle(2);

        // 5: random gaps
        send_word_gaps(8'h3C);
        idle(2);

        // 6: reset mid-word and while holding a word
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        do_reset();
        out_ready = 1'b0;
        send_word(8'hC3, 1'b0);
        idle(2);
        do_reset();
        out_ready = 1'b1;
        send_word(8'h81, 1'b0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
